// File: rtl/dzcpu_useq_pkg.sv
// Shared codes for the dzcpu microcode sequencer: flow states, sequencing cmds,
// end-of-flow condition codes and the eof evaluation helper.
package dzcpu_useq_pkg;

  typedef enum logic [1:0] {
    DZSEQ_AFTER_RESET = 2'd0,
    DZSEQ_START_FLOW  = 2'd1,
    DZSEQ_RUN_FLOW    = 2'd2,
    DZSEQ_END_FLOW    = 2'd3
  } useq_state_e;

  // Sequencing cmds; every other cmd value is a datapath op that just advances uPC.
  localparam logic [3:0] CMD_NOP   = 4'h0;
  localparam logic [3:0] CMD_JCB   = 4'h1;
  localparam logic [3:0] CMD_UJMP  = 4'h2;
  localparam logic [3:0] CMD_UCALL = 4'h3;
  localparam logic [3:0] CMD_URET  = 4'h4;

  localparam logic [2:0] EOFC_NEVER  = 3'b000;
  localparam logic [2:0] EOFC_ALWAYS = 3'b100;
  localparam logic [2:0] EOFC_Z      = 3'b101;
  localparam logic [2:0] EOFC_NZ     = 3'b110;
  localparam logic [2:0] EOFC_C      = 3'b111;
  localparam logic [2:0] EOFC_NC     = 3'b001;

  localparam int FLAG_Z = 7;
  localparam int FLAG_C = 4;

  // uop layout above the operand: {ipc[1], eofc[3], cmd[4]}
  localparam int UOP_CTRL_W = 8;

  function automatic logic eofHit(input logic [2:0] eofc, input logic [7:0] flags);
    case (eofc)
      EOFC_ALWAYS: eofHit = 1'b1;
      EOFC_Z:      eofHit = flags[FLAG_Z];
      EOFC_NZ:     eofHit = !flags[FLAG_Z];
      EOFC_C:      eofHit = flags[FLAG_C];
      EOFC_NC:     eofHit = !flags[FLAG_C];
      default:     eofHit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dzcpu_ustack.sv
// Micro-return LIFO: push is dropped when full, pop is ignored when empty;
// oTop is the most recent entry and is valid only when not empty.
module dzcpu_ustack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iClear,
  input  logic             iPush,
  input  logic             iPop,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oTop,
  output logic             oFull,
  output logic             oEmpty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [2**IDX_W];
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countDec;

  assign oFull    = (count == CNT_W'(DEPTH));
  assign oEmpty   = (count == '0);
  assign countDec = count - 1'b1;
  assign oTop     = mem[countDec[IDX_W-1:0]];

  always_ff @(posedge iClock) begin
    if (iReset || iClear) begin
      count <= '0;
    end else if (iPush && !oFull) begin
      count <= count + 1'b1;
    end else if (iPop && !oEmpty) begin
      count <= countDec;
    end
  end

  // Storage carries no reset; only the occupancy count defines validity.
  always_ff @(posedge iClock) begin
    if (iPush && !oFull && !iClear) begin
      mem[count[IDX_W-1:0]] <= iData;
    end
  end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: flow FSM and micro-PC. Define DZCPU_USEQ_STACK_EN
// to enable ucall/uret through dzcpu_ustack; otherwise both behave as NOP.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int UPC_W       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic [UOP_CTRL_W+UPC_W-1:0] iUop,
  input  logic [UPC_W-1:0]            iBasicIdx,
  input  logic [UPC_W-1:0]            iExtIdx,
  input  logic [7:0]                  iFlags,
  input  logic                        iStall,
  output logic [UPC_W-1:0]            oUpc,
  output logic                        oFlowEnable,
  output logic                        oIncPc,
  output logic [3:0]                  oCmd,
  output logic                        oFlowStart,
  output logic                        oUerr
);

  useq_state_e      stateReg, stateNext;
  logic [UPC_W-1:0] upcReg, upcNext, upcInc;
  logic             ipc;
  logic [2:0]       eofc;
  logic [3:0]       cmd;
  logic [UPC_W-1:0] operand;
  logic             flowEnable;
  logic             eof;

  assign {ipc, eofc, cmd, operand} = iUop;
  assign upcInc     = upcReg + 1'b1;
  assign flowEnable = (stateReg == DZSEQ_RUN_FLOW) && !iStall;
  assign eof        = eofHit(eofc, iFlags);

  assign oUpc        = upcReg;
  assign oFlowEnable = flowEnable;
  assign oIncPc      = ipc && flowEnable;
  assign oCmd        = flowEnable ? cmd : CMD_NOP;
  assign oFlowStart  = (stateReg == DZSEQ_START_FLOW);

`ifdef DZCPU_USEQ_STACK_EN
  logic             uerrReg, uerrNext;
  logic             stackPush, stackPop, stackClear, stackFull, stackEmpty;
  logic [UPC_W-1:0] stackTop;

  dzcpu_ustack #(
    .WIDTH (UPC_W),
    .DEPTH (STACK_DEPTH)
  ) uStack (
    .iClock (iClock),
    .iReset (iReset),
    .iClear (stackClear),
    .iPush  (stackPush),
    .iPop   (stackPop),
    .iData  (upcInc),
    .oTop   (stackTop),
    .oFull  (stackFull),
    .oEmpty (stackEmpty)
  );

  always_ff @(posedge iClock) begin
    if (iReset) uerrReg <= 1'b0;
    else        uerrReg <= uerrNext;
  end

  assign oUerr = uerrReg;
`else
  localparam int unusedStackDepth = STACK_DEPTH;
  assign oUerr = 1'b0;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      stateReg <= DZSEQ_AFTER_RESET;
      upcReg   <= '0;
    end else begin
      stateReg <= stateNext;
      upcReg   <= upcNext;
    end
  end

  // A stall freezes state, uPC and stack in every state; eof is only looked at when enabled.
  always_comb begin
    stateNext = stateReg;
    upcNext   = upcReg;
`ifdef DZCPU_USEQ_STACK_EN
    uerrNext   = uerrReg;
    stackPush  = 1'b0;
    stackPop   = 1'b0;
    stackClear = 1'b0;
`endif
    if (!iStall) begin
      case (stateReg)
        DZSEQ_AFTER_RESET: stateNext = DZSEQ_START_FLOW;
        DZSEQ_START_FLOW: begin
          upcNext   = iBasicIdx;
          stateNext = DZSEQ_RUN_FLOW;
`ifdef DZCPU_USEQ_STACK_EN
          stackClear = 1'b1;
`endif
        end
        DZSEQ_RUN_FLOW: begin
          if (eof) begin
            stateNext = DZSEQ_END_FLOW;
          end else begin
            case (cmd)
              CMD_JCB:  upcNext = iExtIdx;
              CMD_UJMP: upcNext = operand;
`ifdef DZCPU_USEQ_STACK_EN
              CMD_UCALL: begin
                stackPush = 1'b1;
                upcNext   = operand;
                if (stackFull) uerrNext = 1'b1;
              end
              CMD_URET: begin
                if (stackEmpty) begin
                  upcNext  = '0;
                  uerrNext = 1'b1;
                end else begin
                  stackPop = 1'b1;
                  upcNext  = stackTop;
                end
              end
`endif
              default:  upcNext = upcInc;
            endcase
          end
        end
        default: stateNext = DZSEQ_START_FLOW;
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_useq.sv
// Self-checking bench for dzcpu_useq: directed flows plus random ROM/flags/stall/reset,
// all compared cycle by cycle against a phase/queue reference model.
module tb_dzcpu_useq;

  localparam int DEPTH = 4;
  localparam logic [3:0] NOP = 4'h0, JCB = 4'h1, UJMP = 4'h2, UCALL = 4'h3, URET = 4'h4;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iStall = 1'b0;
  logic [15:0] iUop;
  logic [7:0]  iBasicIdx = 8'h00, iExtIdx = 8'h00, iFlags = 8'h00;
  logic [7:0]  oUpc;
  logic        oFlowEnable, oIncPc, oFlowStart, oUerr;
  logic [3:0]  oCmd;
  logic [15:0] dutVec;

  logic [15:0] rom [256];
  int          mPhase, mUpc;   // phase: 0 after reset, 1 start, 2 run, 3 end
  int          mStack[$];
  logic        mUerr;
  int          total = 0, bad = 0;

  always #5 iClock = ~iClock;

  assign iUop   = rom[oUpc];
  assign dutVec = {oUpc, oFlowEnable, oIncPc, oCmd, oFlowStart, oUerr};

  dzcpu_useq dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iUop        (iUop),
    .iBasicIdx   (iBasicIdx),
    .iExtIdx     (iExtIdx),
    .iFlags      (iFlags),
    .iStall      (iStall),
    .oUpc        (oUpc),
    .oFlowEnable (oFlowEnable),
    .oIncPc      (oIncPc),
    .oCmd        (oCmd),
    .oFlowStart  (oFlowStart),
    .oUerr       (oUerr)
  );

  function automatic logic [15:0] mk(input logic ipc, input logic [2:0] eofc,
                                     input logic [3:0] cmd, input logic [7:0] opnd);
    return {ipc, eofc, cmd, opnd};
  endfunction

  function automatic logic modelEof(input logic [2:0] eofc, input logic [7:0] flags);
    if (eofc == 3'b100) return 1'b1;
    if (eofc == 3'b101) return flags[7];
    if (eofc == 3'b110) return !flags[7];
    if (eofc == 3'b111) return flags[4];
    if (eofc == 3'b001) return !flags[4];
    return 1'b0;
  endfunction

  function automatic logic [15:0] expVec();
    logic [15:0] u;
    logic        en;
    logic [7:0]  upc8;
    u    = rom[mUpc];
    en   = (mPhase == 2) && !iStall;
    upc8 = 8'(mUpc);
    return {upc8, en, en & u[15], en ? u[11:8] : 4'h0, (mPhase == 1), mUerr};
  endfunction

  // Apply the effect of the coming clock edge to the model.
  task automatic advance();
    logic [15:0] u;
    u = rom[mUpc];
    if (iReset) begin
      mPhase = 0; mUpc = 0; mStack.delete(); mUerr = 1'b0;
    end else if (!iStall) begin
      if (mPhase == 0) mPhase = 1;
      else if (mPhase == 1) begin
        mUpc = int'(iBasicIdx); mStack.delete(); mPhase = 2;
      end else if (mPhase == 3) mPhase = 1;
      else if (modelEof(u[14:12], iFlags)) mPhase = 3;
      else if (u[11:8] == JCB) mUpc = int'(iExtIdx);
      else if (u[11:8] == UJMP) mUpc = int'(u[7:0]);
`ifdef DZCPU_USEQ_STACK_EN
      else if (u[11:8] == UCALL) begin
        if (mStack.size() < DEPTH) mStack.push_back((mUpc + 1) % 256);
        else mUerr = 1'b1;
        mUpc = int'(u[7:0]);
      end else if (u[11:8] == URET) begin
        if (mStack.size() == 0) begin mUpc = 0; mUerr = 1'b1; end
        else mUpc = mStack.pop_back();
      end
`endif
      else mUpc = (mUpc + 1) % 256;
    end
  endtask

  task automatic tick(input logic rst, input logic stl, input logic [7:0] flags,
                      input logic [7:0] basic, input logic [7:0] ext);
    @(negedge iClock);
    iReset = rst; iStall = stl; iFlags = flags; iBasicIdx = basic; iExtIdx = ext;
    #1;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = mk(1'b0, 3'b100, NOP, 8'h00);
  endtask

  task automatic test_reset();
    clear_rom();
    tick(1'b1, 1'b0, 8'h00, 8'h10, 8'h80);
    advance();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 8'h00, 8'h10, 8'h80);
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, dutVec, expVec());
      end
      total++;
      if (dutVec !== 16'h0000) begin
        bad++; $display("FAIL reset_zero cyc=%0d got=%h exp=0000", i, dutVec);
      end
      advance();
    end
  endtask

  task automatic test_basic_flow();
    clear_rom();
    rom[8'h10] = mk(1'b1, 3'b000, NOP, 8'h00);
    rom[8'h11] = mk(1'b0, 3'b000, 4'h7, 8'h00);
    rom[8'h12] = mk(1'b1, 3'b100, 4'h9, 8'h00);
    for (int i = 0; i < 12; i++) begin
      tick(i == 0, 1'b0, 8'h00, 8'h10, 8'h80);
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("FAIL basic_flow cyc=%0d got=%h exp=%h", i, dutVec, expVec());
      end
      advance();
    end
  endtask

  task automatic test_jcb_eof();
    clear_rom();
    rom[8'h10] = mk(1'b0, 3'b000, JCB, 8'h00);
    rom[8'h80] = mk(1'b1, 3'b101, 4'h5, 8'h00);
    rom[8'h81] = mk(1'b0, 3'b111, 4'h6, 8'h00);
    rom[8'h82] = mk(1'b1, 3'b001, 4'h8, 8'h00);
    for (int i = 0; i < 22; i++) begin
      tick(i == 0, 1'b0, (i < 8) ? 8'h80 : ((i < 15) ? 8'h00 : 8'h10), 8'h10, 8'h80);
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("FAIL jcb_eof cyc=%0d got=%h exp=%h", i, dutVec, expVec());
      end
      advance();
    end
  endtask

  task automatic test_call_ret();
    clear_rom();
    rom[8'h10] = mk(1'b0, 3'b000, NOP, 8'h00);
    rom[8'h11] = mk(1'b0, 3'b000, NOP, 8'h00);
    rom[8'h12] = mk(1'b1, 3'b000, UCALL, 8'h40);
    rom[8'h40] = mk(1'b0, 3'b000, URET, 8'h00);
    rom[8'h20] = mk(1'b0, 3'b000, UCALL, 8'h50);
    rom[8'h50] = mk(1'b0, 3'b000, UCALL, 8'h60);
    rom[8'h60] = mk(1'b0, 3'b000, UCALL, 8'h70);
    rom[8'h70] = mk(1'b0, 3'b000, UCALL, 8'h90);
    rom[8'h90] = mk(1'b0, 3'b000, UCALL, 8'hA0);
    rom[8'hA0] = mk(1'b0, 3'b000, URET, 8'h00);
    rom[8'h71] = mk(1'b0, 3'b000, URET, 8'h00);
    rom[8'h61] = mk(1'b0, 3'b000, URET, 8'h00);
    rom[8'h51] = mk(1'b0, 3'b000, URET, 8'h00);
    rom[8'h21] = mk(1'b0, 3'b000, URET, 8'h00);
    for (int i = 0; i < 30; i++) begin
      tick(i == 0, 1'b0, 8'h00, (i < 9) ? 8'h10 : 8'h20, 8'h80);
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("FAIL call_ret cyc=%0d got=%h exp=%h", i, dutVec, expVec());
      end
      advance();
    end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[8'h10] = mk(1'b1, 3'b000, 4'h5, 8'h00);
    rom[8'h11] = mk(1'b1, 3'b100, 4'h6, 8'h00);
    for (int i = 0; i < 14; i++) begin
      tick(i == 0, (i >= 4 && i <= 6) || i == 10, 8'h00, 8'h10, 8'h80);
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("FAIL stall cyc=%0d got=%h exp=%h", i, dutVec, expVec());
      end
      advance();
    end
  endtask

  task automatic test_reset_midflow();
    clear_rom();
    rom[8'h10] = mk(1'b0, 3'b000, UCALL, 8'h30);
    rom[8'h30] = mk(1'b0, 3'b000, UCALL, 8'h50);
    rom[8'h50] = mk(1'b1, 3'b000, NOP, 8'h00);
    rom[8'h51] = mk(1'b1, 3'b000, NOP, 8'h00);
    rom[8'h52] = mk(1'b0, 3'b000, URET, 8'h00);
    for (int i = 0; i < 14; i++) begin
      tick(i == 0 || i == 6, 1'b0, 8'h00, 8'h10, 8'h80);
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("FAIL reset_midflow cyc=%0d got=%h exp=%h", i, dutVec, expVec());
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [2:0] e;
    for (int a = 0; a < 256; a++) begin
      e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rom[a] = mk(1'($urandom_range(0, 1)), e, 4'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 1500; i++) begin
      tick(i == 0 || $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dutVec, expVec());
      end
      advance();
    end
  endtask

  initial begin
    mPhase = 0; mUpc = 0; mUerr = 1'b0;
    test_reset();
    test_basic_flow();
    test_jcb_eof();
    test_call_ret();
    test_stall();
    test_reset_midflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
